// File: rtl/fc_issue_ctrl_if.sv
// rtl/fc_issue_ctrl_if.sv - handshake bundle between the FC issue controller and its neighbours
//
// Purpose: groups the start/status, feature-source, FC-pipeline and result-buffer
// signals of fc_issue_ctrl. The master modport is the controller's view, the
// slave modport is the environment's view (sequencer, feature reader, FC datapath,
// result buffer).
//
// Signals:
//   start        sequencer -> ctrl   one-cycle pulse, begins a pass
//   src_valid    reader    -> ctrl   feature source has a beat
//   src_ready    ctrl      -> reader beat can be accepted this cycle
//   valid_in_FC  ctrl      -> FC     one cycle per accepted beat
//   rd_addr      ctrl      -> FC     beat index aligned with valid_in_FC
//   valid_out_FC FC        -> ctrl   result return
//   sink_pop     buffer    -> ctrl   result buffer freed one entry
//   busy/done    ctrl      -> sequencer
//   err_proto/err_timeout ctrl -> sequencer, sticky
interface fc_issue_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              src_valid;
  logic              src_ready;
  logic              valid_in_FC;
  logic [ADDR_W-1:0] rd_addr;
  logic              valid_out_FC;
  logic              sink_pop;
  logic              busy;
  logic              done;
  logic              err_proto;
  logic              err_timeout;

  modport master (
    input  start, src_valid, valid_out_FC, sink_pop,
    output src_ready, valid_in_FC, rd_addr, busy, done, err_proto, err_timeout
  );

  modport slave (
    output start, src_valid, valid_out_FC, sink_pop,
    input  src_ready, valid_in_FC, rd_addr, busy, done, err_proto, err_timeout
  );
endinterface

// File: rtl/fc_issue_ctrl.sv
// rtl/fc_issue_ctrl.sv - FC valid-pipeline issue controller with credit throttling and drain watchdog
//
// Purpose: issues NUM_BEATS feature beats per pass into the non-stallable FC
// pipeline, throttled by a credit counter that mirrors the downstream result
// buffer, then waits for every result to return. Reports busy/done and sticky
// protocol / timeout errors.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   fc_issue_ctrl_if.master (start, src_valid/src_ready, valid_in_FC,
//         rd_addr, valid_out_FC, sink_pop, busy, done, err_proto, err_timeout)
module fc_issue_ctrl #(
  parameter int NUM_BEATS = 512,
  parameter int ADDR_W    = 10,
  parameter int PIPE_LAT  = 6,
  parameter int CREDITS   = 8,
  parameter int WDOG      = 64
) (
  input  logic            clk,
  input  logic            rst,
  fc_issue_ctrl_if.master bus
);

  // A watchdog shorter than the pipeline would fire on every healthy pass,
  // so the effective limit never drops below PIPE_LAT+1.
  localparam int WDOG_LIM = (WDOG > PIPE_LAT) ? WDOG : PIPE_LAT + 1;
  localparam int CW       = $clog2(CREDITS + 1);
  localparam int WW       = $clog2(WDOG_LIM + 1);

  localparam logic [ADDR_W:0] BEATS     = (ADDR_W + 1)'(NUM_BEATS);
  localparam logic [ADDR_W:0] BEATS_M1  = (ADDR_W + 1)'(NUM_BEATS - 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [CW-1:0]   CRED_MAX  = CW'(CREDITS);
  localparam logic [CW-1:0]   CRED_ONE  = CW'(1);
  localparam logic [WW-1:0]   WDOG_LAST = WW'(WDOG_LIM - 1);
  localparam logic [WW-1:0]   WDOG_ONE  = WW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   returned;
  logic [CW-1:0]     credit;
  logic [WW-1:0]     wdog;

  logic              valid_in_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_proto_q;
  logic              err_timeout_q;

  logic              src_ready_w;
  logic              accept;
  logic              start_pass;
  logic              in_pass;
  logic              ret_ok;
  logic              ret_bad;
  logic              pop_over;
  logic              issue_last;
  logic              return_last;
  logic              wdog_fire;

  // ---------------------------------------------------------------------------
  // Handshake and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    src_ready_w = (state == S_ISSUE) && (credit != '0) && (issued < BEATS);
    accept      = bus.src_valid && src_ready_w;
    start_pass  = (state == S_IDLE) && bus.start;
    in_pass     = (state == S_ISSUE) || (state == S_DRAIN);

    // A return is only legitimate while a pass runs and at least one beat is
    // still in flight; anything else is flagged and not counted.
    ret_ok      = bus.valid_out_FC && in_pass && (returned != issued);
    ret_bad     = bus.valid_out_FC && !ret_ok;

    // A pop against a full credit count means the buffer freed an entry we
    // never filled. A simultaneous accept consumes it, so that case is legal.
    pop_over    = bus.sink_pop && !accept && (credit == CRED_MAX);

    issue_last  = accept && (issued == BEATS_M1);
    return_last = ret_ok && (returned == BEATS_M1);
    wdog_fire   = (state == S_DRAIN) && !ret_ok && (wdog == WDOG_LAST);
  end

  // ---------------------------------------------------------------------------
  // Pass FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_ISSUE;
      S_ISSUE: if (issue_last) state_nxt = S_DRAIN;
      S_DRAIN: if (return_last || wdog_fire) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat, return and watchdog counters
  // ---------------------------------------------------------------------------
  // issued/returned cannot pass NUM_BEATS: accept requires issued < NUM_BEATS
  // and ret_ok requires returned < issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued   <= '0;
      returned <= '0;
      wdog     <= '0;
    end else if (start_pass) begin
      issued   <= '0;
      returned <= '0;
      wdog     <= '0;
    end else begin
      if (accept) begin
        issued <= issued + CNT_ONE;
      end
      if (ret_ok) begin
        returned <= returned + CNT_ONE;
      end
      if (state == S_DRAIN) begin
        wdog <= ret_ok ? '0 : wdog + WDOG_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter: one credit per free result-buffer entry
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= CRED_MAX;
    end else if (accept && !bus.sink_pop) begin
      credit <= credit - CRED_ONE;
    end else if (!accept && bus.sink_pop && (credit != CRED_MAX)) begin
      credit <= credit + CRED_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_in_q    <= 1'b0;
      rd_addr_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      valid_in_q <= accept;
      if (accept) begin
        rd_addr_q <= issued[ADDR_W-1:0];
      end
      busy_q        <= (state_nxt == S_ISSUE) || (state_nxt == S_DRAIN);
      done_q        <= (state_nxt == S_DONE);
      err_proto_q   <= err_proto_q | ret_bad | pop_over;
      err_timeout_q <= err_timeout_q | wdog_fire;
    end
  end

  assign bus.src_ready   = src_ready_w;
  assign bus.valid_in_FC = valid_in_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_proto   = err_proto_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_fc_issue_ctrl.sv
// tb/tb_fc_issue_ctrl.sv - scoreboard bench for fc_issue_ctrl
module tb_fc_issue_ctrl;

  localparam int NB   = 4;
  localparam int AW   = 3;
  localparam int PL   = 6;
  localparam int WD   = 16;
  localparam int CR_A = 8;
  localparam int CR_B = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fc_issue_ctrl_if #(.ADDR_W(AW)) bus_a ();
  fc_issue_ctrl_if #(.ADDR_W(AW)) bus_b ();

  fc_issue_ctrl #(
    .NUM_BEATS(NB), .ADDR_W(AW), .PIPE_LAT(PL), .CREDITS(CR_A), .WDOG(WD)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master)
  );

  fc_issue_ctrl #(
    .NUM_BEATS(NB), .ADDR_W(AW), .PIPE_LAT(PL), .CREDITS(CR_B), .WDOG(WD)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master)
  );

  int n_chk = 0;
  int n_err = 0;
  int rel   = 0;

  int exp_addr_a[$];
  int exp_cyc_a[$];
  int exp_addr_b[$];
  int exp_cyc_b[$];
  int mon_addr;
  int mon_cyc;

  int done_a = 0;
  int done_b = 0;

  logic [6:0] ha;
  logic [6:0] hb;
  int  ret_idx_a = 0;
  int  drop_a    = -1;
  bit  auto_pop_a = 1'b0;
  bit  prev_ret_a = 1'b0;
  bit  ret_a;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_a(input int addr, input int cyc);
    exp_addr_a.push_back(addr);
    exp_cyc_a.push_back(cyc);
  endtask

  task automatic push_b(input int addr, input int cyc);
    exp_addr_b.push_back(addr);
    exp_cyc_b.push_back(cyc);
  endtask

  // Advance one cycle; leaves time at posedge+1 with environment inputs set
  // for the new cycle. The FC pipeline is a 6-deep valid delay line and the
  // result buffer of A pops each result one cycle after it arrives.
  task automatic tick();
    @(posedge clk);
    #1;
    rel++;
    ha    = {ha[5:0], bus_a.valid_in_FC};
    ret_a = ha[6];
    if (ha[6]) begin
      if (ret_idx_a == drop_a) ret_a = 1'b0;
      ret_idx_a++;
    end
    bus_a.valid_out_FC = ret_a;
    bus_a.sink_pop     = auto_pop_a && prev_ret_a;
    prev_ret_a         = ret_a;
    bus_a.start        = 1'b0;

    hb = {hb[5:0], bus_b.valid_in_FC};
    bus_b.valid_out_FC = hb[6];
    bus_b.sink_pop     = 1'b0;
    bus_b.start        = 1'b0;
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    rel         = 0;
    ret_idx_a   = 0;
    done_a      = 0;
  endtask

  task automatic start_b();
    bus_b.start = 1'b1;
    rel         = 0;
    done_b      = 0;
  endtask

  task automatic clear_env();
    ha = '0;
    hb = '0;
    prev_ret_a = 1'b0;
    bus_a.start = 1'b0; bus_a.src_valid = 1'b0; bus_a.valid_out_FC = 1'b0; bus_a.sink_pop = 1'b0;
    bus_b.start = 1'b0; bus_b.src_valid = 1'b0; bus_b.valid_out_FC = 1'b0; bus_b.sink_pop = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_env();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Scoreboard monitor: every valid_in_FC pops one expected beat.
  always @(negedge clk) begin
    if (rst) begin
      if (bus_a.valid_in_FC) begin
        check("a_sb_has_entry", int'(exp_addr_a.size() != 0), 1);
        if (exp_addr_a.size() != 0) begin
          mon_addr = exp_addr_a.pop_front();
          mon_cyc  = exp_cyc_a.pop_front();
          check("a_rd_addr", int'(bus_a.rd_addr), mon_addr);
          if (mon_cyc >= 0) check("a_beat_cycle", rel, mon_cyc);
        end
      end
      if (bus_b.valid_in_FC) begin
        check("b_sb_has_entry", int'(exp_addr_b.size() != 0), 1);
        if (exp_addr_b.size() != 0) begin
          mon_addr = exp_addr_b.pop_front();
          mon_cyc  = exp_cyc_b.pop_front();
          check("b_rd_addr", int'(bus_b.rd_addr), mon_addr);
          if (mon_cyc >= 0) check("b_beat_cycle", rel, mon_cyc);
        end
      end
      if (bus_a.done) done_a++;
      if (bus_b.done) done_b++;
    end
  end

  initial begin
    rst = 1'b0;
    clear_env();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    check("rst_src_ready",   int'(bus_a.src_ready), 0);
    check("rst_valid_in",    int'(bus_a.valid_in_FC), 0);
    check("rst_rd_addr",     int'(bus_a.rd_addr), 0);
    check("rst_busy",        int'(bus_a.busy), 0);
    check("rst_done",        int'(bus_a.done), 0);
    check("rst_err_proto",   int'(bus_a.err_proto), 0);
    check("rst_err_timeout", int'(bus_a.err_timeout), 0);
    check("rst_credit_a",    int'(u_dut_a.credit), CR_A);
    check("rst_credit_b",    int'(u_dut_b.credit), CR_B);

    // Basic pass: beats in cycles 2..5, returns 8..11, done in 12
    tick();
    bus_a.src_valid = 1'b1;
    auto_pop_a = 1'b1;
    for (int i = 0; i < NB; i++) push_a(i, i + 2);
    start_a();
    for (int i = 0; i < 20; i++) begin
      tick();
      case (rel)
        1:  begin check("basic_ready_c1", int'(bus_a.src_ready), 1); check("basic_busy_c1", int'(bus_a.busy), 1); end
        5:  check("basic_ready_drain", int'(bus_a.src_ready), 0);
        11: begin check("basic_done_c11", int'(bus_a.done), 0); check("basic_busy_c11", int'(bus_a.busy), 1); end
        12: begin
              check("basic_done_c12", int'(bus_a.done), 1);
              check("basic_busy_c12", int'(bus_a.busy), 0);
              check("basic_returned", int'(u_dut_a.returned), NB);
            end
        13: check("basic_done_c13", int'(bus_a.done), 0);
        default: ;
      endcase
    end
    bus_a.src_valid = 1'b0;
    check("basic_sb_empty",   exp_addr_a.size(), 0);
    check("basic_done_count", done_a, 1);
    check("basic_credit",     int'(u_dut_a.credit), CR_A);
    check("basic_err_proto",  int'(bus_a.err_proto), 0);
    check("basic_err_to",     int'(bus_a.err_timeout), 0);

    // Source gaps: src_valid high only in odd cycles
    tick();
    for (int i = 0; i < NB; i++) push_a(i, 2 * i + 2);
    bus_a.src_valid = 1'b0;
    start_a();
    for (int i = 0; i < 40; i++) begin
      tick();
      bus_a.src_valid = rel[0];
    end
    bus_a.src_valid = 1'b0;
    check("gap_sb_empty",   exp_addr_a.size(), 0);
    check("gap_done_count", done_a, 1);
    check("gap_returned",   int'(u_dut_a.returned), NB);
    check("gap_busy_end",   int'(bus_a.busy), 0);

    // Watchdog: last return dropped; prior return in cycle 10
    tick();
    drop_a = NB - 1;
    bus_a.src_valid = 1'b1;
    for (int i = 0; i < NB; i++) push_a(i, i + 2);
    start_a();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rel == 10 + WD) begin
        check("wdog_not_yet", int'(bus_a.err_timeout), 0);
        check("wdog_no_done_yet", int'(bus_a.done), 0);
      end
      if (rel == 10 + WD + 1) begin
        check("wdog_err_set", int'(bus_a.err_timeout), 1);
        check("wdog_done", int'(bus_a.done), 1);
      end
    end
    bus_a.src_valid = 1'b0;
    drop_a = -1;
    check("wdog_done_count", done_a, 1);
    check("wdog_sb_empty",   exp_addr_a.size(), 0);
    check("wdog_credit",     int'(u_dut_a.credit), CR_A - 1);
    check("wdog_err_proto",  int'(bus_a.err_proto), 0);

    // Clean pass after the timeout, error stays sticky
    tick();
    bus_a.src_valid = 1'b1;
    for (int i = 0; i < NB; i++) push_a(i, i + 2);
    start_a();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rel == 12) check("clean_done_c12", int'(bus_a.done), 1);
    end
    bus_a.src_valid = 1'b0;
    check("clean_done_count", done_a, 1);
    check("clean_sb_empty",   exp_addr_a.size(), 0);
    check("clean_err_to",     int'(bus_a.err_timeout), 1);
    check("clean_err_proto",  int'(bus_a.err_proto), 0);

    // Reset mid-pass with issued=3 and beat 2 on the bus
    tick();
    bus_a.src_valid = 1'b1;
    push_a(0, 2);
    push_a(1, 3);
    start_a();
    repeat (3) tick();
    tick();
    bus_a.src_valid = 1'b0;
    check("mid_issued",   int'(u_dut_a.issued), 3);
    check("mid_valid_in", int'(bus_a.valid_in_FC), 1);
    check("mid_busy",     int'(bus_a.busy), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid_in",  int'(bus_a.valid_in_FC), 0);
    check("arst_rd_addr",   int'(bus_a.rd_addr), 0);
    check("arst_busy",      int'(bus_a.busy), 0);
    check("arst_done",      int'(bus_a.done), 0);
    check("arst_src_ready", int'(bus_a.src_ready), 0);
    check("arst_err_to",    int'(bus_a.err_timeout), 0);
    check("arst_err_proto", int'(bus_a.err_proto), 0);
    clear_env();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("mid_no_done",   done_a, 0);
    check("mid_credit",    int'(u_dut_a.credit), CR_A);
    check("mid_sb_empty",  exp_addr_a.size(), 0);

    // Protocol: pop with full credit
    tick();
    bus_a.sink_pop = 1'b1;
    tick();
    check("popover_err",    int'(bus_a.err_proto), 1);
    check("popover_credit", int'(u_dut_a.credit), CR_A);
    apply_reset();
    check("proto_cleared", int'(bus_a.err_proto), 0);

    // Protocol: return while idle
    tick();
    bus_a.valid_out_FC = 1'b1;
    tick();
    check("idle_ret_err",      int'(bus_a.err_proto), 1);
    check("idle_ret_returned", int'(u_dut_a.returned), 0);
    apply_reset();

    // Credit stall on the 2-credit instance
    auto_pop_a = 1'b0;
    tick();
    bus_b.src_valid = 1'b1;
    push_b(0, 2);
    push_b(1, 3);
    push_b(2, 22);
    push_b(3, 26);
    start_b();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rel >= 3 && rel <= 20) check("stall_ready_low", int'(bus_b.src_ready), 0);
      case (rel)
        20: bus_b.sink_pop = 1'b1;
        21: begin check("stall_resume_ready", int'(bus_b.src_ready), 1); check("stall_credit_c21", int'(u_dut_b.credit), 1); end
        22: check("stall_credit_c22", int'(u_dut_b.credit), 0);
        24: bus_b.sink_pop = 1'b1;
        25: begin bus_b.sink_pop = 1'b1; check("stall_ready_c25", int'(bus_b.src_ready), 1); end
        26: begin check("acc_pop_credit", int'(u_dut_b.credit), 1); check("stall_busy_drain", int'(bus_b.busy), 1); end
        33: check("stall_done_c33", int'(bus_b.done), 1);
        35: bus_b.sink_pop = 1'b1;
        default: ;
      endcase
    end
    bus_b.src_valid = 1'b0;
    check("stall_sb_empty",   exp_addr_b.size(), 0);
    check("stall_done_count", done_b, 1);
    check("stall_credit_end", int'(u_dut_b.credit), CR_B);
    check("stall_err_proto",  int'(bus_b.err_proto), 0);
    check("stall_err_to",     int'(bus_b.err_timeout), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
